fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage for the five-stage ARM64 pipeline: owns the PC, drives the combinational instruction memory, and loads the IF/ID boundary register feeding decode. Accepts a branch redirect from the MEM stage and a stall from hazard detection. On redirect it inserts a NOP bubble. Keeps saturating fetch and redirect counters for debug.

## Interface
- NOP_INSTR, 32'hD503201F, encoding placed in id_instr for bubbles
- CNT_W, 32, width of the performance counters
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- startpc  in  64  PC loaded while reset is high
- stall  in  1  from hazard unit: hold PC and IF/ID
- redirect  in  1  from MEM stage: taken branch or unconditional branch
- redirect_target  in  64  branch target PC
- imem_addr  out  64  address to the instruction memory (equals currentpc)
- imem_data  in  32  instruction returned combinationally for imem_addr
- currentpc  out  64  current fetch PC
- id_instr  out  32  IF/ID instruction
- id_nextseqpc  out  64  IF/ID PC+4 of that instruction
- id_valid  out  1  IF/ID holds a real instruction (0 = bubble)
- fetch_state  out  2  FSM state, for debug
- fetch_count  out  CNT_W  valid instructions loaded into IF/ID, saturating
- redirect_count  out  CNT_W  accepted redirects, saturating

## Operation
- FSM states, encoded in a package: RESET=0, RUN=1, STALLED=2, REDIRECT=3.
- Priority on each edge: reset > redirect > stall > normal.
- reset high:
  - pc <= {startpc[63:2],2'b00}
  - IF/ID <= bubble (id_instr=NOP_INSTR, id_nextseqpc=0, id_valid=0)
  - counters <= 0
  - state <= RESET
- Normal (RESET, RUN or REDIRECT, no stall, no redirect):
  - pc <= pc+4, wrapping modulo 2^64
  - IF/ID <= {imem_data, pc+4, valid=1}
  - fetch_count increments
  - state <= RUN
- stall, no redirect:
  - pc and IF/ID hold; counters hold
  - state <= STALLED, which persists while stall stays high
  - stall released: normal fetch resumes from the held pc
- redirect (overrides stall):
  - pc <= {redirect_target[63:2],2'b00}
  - IF/ID <= bubble
  - redirect_count increments
  - state <= REDIRECT
  - back-to-back redirects are each accepted; the last target wins
- Counters saturate at all-ones and never wrap.
- imem_addr = currentpc = pc.
- The MEM-stage redirect leaves two wrong-path instructions already in ID and EX. Squashing those is the pipeline top's job, via ID/EX and EX/MEM flush.

## Timing
- Reset values: currentpc = aligned startpc one edge after reset is sampled; id_instr = NOP_INSTR; id_nextseqpc = 0; id_valid = 0; fetch_state = RESET; both counters 0.
- Fetch latency is 1 cycle: the instruction at pc in cycle N is on id_instr in cycle N+1.
- Redirect asserted in cycle N:
  - cycle N+1: pc = target, id_valid = 0
  - cycle N+2: target instruction in ID with id_valid = 1
- Stall asserted in cycles N..M: outputs frozen during N+1..M+1; the next instruction enters ID in cycle M+2.
- Reset asserted mid-stall or mid-redirect: reset wins on that edge; pending stall and redirect are dropped.
- All outputs are registered except imem_addr and currentpc, which are driven directly from the pc register.

## Structure
- Shared package fetch_pkg holds:
  - fetch_state_t enum (RESET, RUN, STALLED, REDIRECT)
  - NOP encoding constant
  - PC_INC = 64'd4
- One natural sub-module: fetch_ifid_reg, the IF/ID register with load, hold and bubble controls. It replaces the existing ad hoc IF/ID register.
- Saturating counters stay inline.

## Test plan
- Reset and run: startpc=0x1000, reset 2 cycles, then run 4 cycles -> currentpc 0x1000,0x1004,0x1008,0x100C; id_nextseqpc one cycle behind and equal to fetched pc+4; fetch_count=4.
- Stall: at pc=0x1008 hold stall for 3 cycles -> currentpc stays 0x1008; id_instr and id_valid unchanged; fetch_state=STALLED; next ID instruction is the one at 0x1008.
- Redirect: at pc=0x1010 pulse redirect with target 0x2000 -> next cycle currentpc=0x2000 and id_valid=0; following cycle id_instr=imem[0x2000]; redirect_count=1.
- Redirect during stall, target 0x3003: redirect wins -> currentpc=0x3000 (low bits cleared); stall ignored that edge.
- Boundaries:
  - startpc=0xFFFF_FFFF_FFFF_FFFC -> next pc wraps to 0.
  - CNT_W=4, force 20 fetches -> fetch_count stays 15.
- Reset mid-redirect: assert redirect and reset together -> pc=startpc, id_valid=0, redirect_count=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage: the fetch FSM state
// encoding, the NOP used to fill IF/ID bubbles, the sequential PC increment
// and a helper that word-aligns a PC.
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        RESET    = 2'd0,
        RUN      = 2'd1,
        STALLED  = 2'd2,
        REDIRECT = 2'd3
    } fetch_state_t;

    // AArch64 NOP, placed in IF/ID whenever it holds a bubble.
    localparam logic [31:0] NOP_ENCODING = 32'hD503_201F;

    localparam logic [63:0] PC_INC = 64'd4;

    // Instructions are 4-byte aligned; clear the two low address bits.
    function automatic logic [63:0] align_pc(input logic [63:0] addr);
        return addr & ~64'd3;
    endfunction

endpackage : fetch_pkg

// File: rtl/fetch_ifid_reg.sv
// -----------------------------------------------------------------------------
// fetch_ifid_reg
// IF/ID boundary register. Loads a fetched instruction, holds it, or replaces
// it with a NOP bubble. Bubble has priority over load; with neither asserted
// the contents hold.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high reset (register becomes a bubble)
//   i_load       in   capture i_instr / i_nextseqpc as a valid instruction
//   i_bubble     in   replace contents with a NOP bubble
//   i_instr      in   instruction to capture
//   i_nextseqpc  in   PC+4 of that instruction
//   o_instr      out  registered instruction
//   o_nextseqpc  out  registered PC+4
//   o_valid      out  1 = real instruction, 0 = bubble
// -----------------------------------------------------------------------------
module fetch_ifid_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_ENCODING
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_bubble,
    input  logic [31:0] i_instr,
    input  logic [63:0] i_nextseqpc,
    output logic [31:0] o_instr,
    output logic [63:0] o_nextseqpc,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [63:0] r_nextseqpc;
    logic        r_valid;

    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset || i_bubble) begin
            r_instr     <= NOP_INSTR;
            r_nextseqpc <= '0;
            r_valid     <= 1'b0;
        end else if (i_load) begin
            r_instr     <= i_instr;
            r_nextseqpc <= i_nextseqpc;
            r_valid     <= 1'b1;
        end
    end

    assign o_instr     = r_instr;
    assign o_nextseqpc = r_nextseqpc;
    assign o_valid     = r_valid;

endmodule : fetch_ifid_reg

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage of the five-stage ARM64 pipeline. Owns the PC,
// addresses the combinational instruction memory and loads the IF/ID register.
// Priority on every edge: reset > redirect > stall > normal fetch. A redirect
// loads the aligned target and inserts a bubble into IF/ID. Saturating debug
// counters track loaded instructions and accepted redirects.
//
// Ports
//   clk              in   clock, rising edge
//   reset            in   synchronous active-high reset
//   startpc          in   PC loaded (aligned) while reset is high
//   stall            in   hold PC and IF/ID
//   redirect         in   taken/unconditional branch from MEM
//   redirect_target  in   branch target PC (aligned on load)
//   imem_addr        out  instruction memory address (= pc)
//   imem_data        in   instruction at imem_addr, combinational
//   currentpc        out  current fetch PC
//   id_instr         out  IF/ID instruction
//   id_nextseqpc     out  IF/ID PC+4
//   id_valid         out  IF/ID valid (0 = bubble)
//   fetch_state      out  FSM state for debug
//   fetch_count      out  valid instructions loaded, saturating
//   redirect_count   out  accepted redirects, saturating
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_ENCODING,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [63:0]      startpc,
    input  logic             stall,
    input  logic             redirect,
    input  logic [63:0]      redirect_target,
    output logic [63:0]      imem_addr,
    input  logic [31:0]      imem_data,
    output logic [63:0]      currentpc,
    output logic [31:0]      id_instr,
    output logic [63:0]      id_nextseqpc,
    output logic             id_valid,
    output logic [1:0]       fetch_state,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] redirect_count
);

    fetch_state_t     r_state;
    logic [63:0]      r_pc;
    logic [CNT_W-1:0] r_fetch_count;
    logic [CNT_W-1:0] r_redirect_count;

    fetch_state_t     w_next_state;
    logic [63:0]      w_next_pc;
    logic [63:0]      w_seq_pc;
    logic             w_ifid_load;
    logic             w_ifid_bubble;
    logic             w_fetch_inc;
    logic             w_redirect_inc;

    // Sequential PC; 64-bit add wraps naturally at the top of the address space.
    assign w_seq_pc = r_pc + PC_INC;

    // Next-state / control. The decision depends only on redirect and stall,
    // so every state shares the same transitions; reset is applied in the
    // register process because it overrides everything on that edge.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_next_state   = r_state;
        w_next_pc      = r_pc;
        w_ifid_load    = 1'b0;
        w_ifid_bubble  = 1'b0;
        w_fetch_inc    = 1'b0;
        w_redirect_inc = 1'b0;

        if (redirect) begin
            w_next_state   = REDIRECT;
            w_next_pc      = align_pc(redirect_target);
            w_ifid_bubble  = 1'b1;
            w_redirect_inc = 1'b1;
        end else if (stall) begin
            w_next_state = STALLED;
        end else begin
            w_next_state = RUN;
            w_next_pc    = w_seq_pc;
            w_ifid_load  = 1'b1;
            w_fetch_inc  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= RESET;
            r_pc             <= align_pc(startpc);
            r_fetch_count    <= '0;
            r_redirect_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            // Counters stick at all-ones instead of wrapping.
            if (w_fetch_inc && (r_fetch_count != '1)) begin
                r_fetch_count <= r_fetch_count + 1'b1;
            end
            if (w_redirect_inc && (r_redirect_count != '1)) begin
                r_redirect_count <= r_redirect_count + 1'b1;
            end
        end
    end

    fetch_ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_ifid_load),
        .i_bubble    (w_ifid_bubble),
        .i_instr     (imem_data),
        .i_nextseqpc (w_seq_pc),
        .o_instr     (id_instr),
        .o_nextseqpc (id_nextseqpc),
        .o_valid     (id_valid)
    );

    assign imem_addr      = r_pc;
    assign currentpc      = r_pc;
    assign fetch_state    = r_state;
    assign fetch_count    = r_fetch_count;
    assign redirect_count = r_redirect_count;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. Instance dut_a uses 32-bit counters for the
// functional sequence; dut_b uses 4-bit counters for the saturation case.
// The instruction memory returns {4'hE, addr[27:0]}, so the instruction at
// 0x1008 is 32'hE000_1008.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'hD503_201F;
    localparam logic [63:0] ST_RESET    = 64'd0;
    localparam logic [63:0] ST_RUN      = 64'd1;
    localparam logic [63:0] ST_STALLED  = 64'd2;
    localparam logic [63:0] ST_REDIRECT = 64'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut_a
    logic        a_reset, a_stall, a_redirect;
    logic [63:0] a_startpc, a_target, a_imem_addr, a_pc, a_nextseqpc;
    logic [31:0] a_imem_data, a_instr;
    logic        a_valid;
    logic [1:0]  a_state;
    logic [31:0] a_fcnt, a_rcnt;

    // dut_b
    logic        b_reset, b_stall, b_redirect;
    logic [63:0] b_startpc, b_target, b_imem_addr, b_pc, b_nextseqpc;
    logic [31:0] b_imem_data, b_instr;
    logic        b_valid;
    logic [1:0]  b_state;
    logic [3:0]  b_fcnt, b_rcnt;

    assign a_imem_data = {4'hE, a_imem_addr[27:0]};
    assign b_imem_data = {4'hE, b_imem_addr[27:0]};

    fetch_unit #(.CNT_W(32)) dut_a (
        .clk             (clk),
        .reset           (a_reset),
        .startpc         (a_startpc),
        .stall           (a_stall),
        .redirect        (a_redirect),
        .redirect_target (a_target),
        .imem_addr       (a_imem_addr),
        .imem_data       (a_imem_data),
        .currentpc       (a_pc),
        .id_instr        (a_instr),
        .id_nextseqpc    (a_nextseqpc),
        .id_valid        (a_valid),
        .fetch_state     (a_state),
        .fetch_count     (a_fcnt),
        .redirect_count  (a_rcnt)
    );

    fetch_unit #(.CNT_W(4)) dut_b (
        .clk             (clk),
        .reset           (b_reset),
        .startpc         (b_startpc),
        .stall           (b_stall),
        .redirect        (b_redirect),
        .redirect_target (b_target),
        .imem_addr       (b_imem_addr),
        .imem_data       (b_imem_data),
        .currentpc       (b_pc),
        .id_instr        (b_instr),
        .id_nextseqpc    (b_nextseqpc),
        .id_valid        (b_valid),
        .fetch_state     (b_state),
        .fetch_count     (b_fcnt),
        .redirect_count  (b_rcnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one edge and settle past it before sampling outputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the full IF/ID contents of dut_a.
    task automatic check_id(input string tag, input logic [31:0] instr,
                            input logic [63:0] nsp, input logic valid);
        check({tag, ".instr"}, {32'd0, a_instr}, {32'd0, instr});
        check({tag, ".nsp"},   a_nextseqpc, nsp);
        check({tag, ".valid"}, {63'd0, a_valid}, {63'd0, valid});
    endtask

    initial begin
        a_reset = 1'b1; a_stall = 1'b0; a_redirect = 1'b0;
        a_startpc = 64'h1000; a_target = 64'h0;
        b_reset = 1'b1; b_stall = 1'b0; b_redirect = 1'b0;
        b_startpc = 64'h0; b_target = 64'h0;
        #2;

        // ---- reset for two cycles ----
        tick();
        tick();
        check("rst.pc",    a_pc, 64'h1000);
        check("rst.imem",  a_imem_addr, 64'h1000);
        check_id("rst", NOP, 64'h0, 1'b0);
        check("rst.state", {62'd0, a_state}, ST_RESET);
        check("rst.fcnt",  {32'd0, a_fcnt}, 64'd0);
        check("rst.rcnt",  {32'd0, a_rcnt}, 64'd0);

        // ---- run ----
        a_reset = 1'b0;
        tick();
        check("run1.pc", a_pc, 64'h1004);
        check_id("run1", 32'hE000_1000, 64'h1004, 1'b1);
        check("run1.state", {62'd0, a_state}, ST_RUN);
        tick();
        check("run2.pc", a_pc, 64'h1008);
        check_id("run2", 32'hE000_1004, 64'h1008, 1'b1);
        check("run2.fcnt", {32'd0, a_fcnt}, 64'd2);

        // ---- stall three cycles at pc=0x1008 ----
        a_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall.pc", a_pc, 64'h1008);
            check_id("stall", 32'hE000_1004, 64'h1008, 1'b1);
            check("stall.state", {62'd0, a_state}, ST_STALLED);
            check("stall.fcnt", {32'd0, a_fcnt}, 64'd2);
        end
        a_stall = 1'b0;
        tick();
        check("unstall.pc", a_pc, 64'h100C);
        check_id("unstall", 32'hE000_1008, 64'h100C, 1'b1);
        check("unstall.state", {62'd0, a_state}, ST_RUN);
        tick();
        check("run4.pc", a_pc, 64'h1010);
        check("run4.fcnt", {32'd0, a_fcnt}, 64'd4);

        // ---- redirect at pc=0x1010 to 0x2000 ----
        a_redirect = 1'b1; a_target = 64'h2000;
        tick();
        a_redirect = 1'b0;
        check("redir.pc", a_pc, 64'h2000);
        check_id("redir", NOP, 64'h0, 1'b0);
        check("redir.state", {62'd0, a_state}, ST_REDIRECT);
        check("redir.rcnt", {32'd0, a_rcnt}, 64'd1);
        check("redir.fcnt", {32'd0, a_fcnt}, 64'd4);
        tick();
        check("redir2.pc", a_pc, 64'h2004);
        check_id("redir2", 32'hE000_2000, 64'h2004, 1'b1);
        check("redir2.fcnt", {32'd0, a_fcnt}, 64'd5);

        // ---- redirect during stall, unaligned target 0x3003 ----
        a_stall = 1'b1;
        tick();
        check("st2.pc", a_pc, 64'h2004);
        a_redirect = 1'b1; a_target = 64'h3003;
        tick();
        a_redirect = 1'b0;
        check("rds.pc", a_pc, 64'h3000);
        check_id("rds", NOP, 64'h0, 1'b0);
        check("rds.state", {62'd0, a_state}, ST_REDIRECT);
        check("rds.rcnt", {32'd0, a_rcnt}, 64'd2);
        tick();
        check("rds2.pc", a_pc, 64'h3000);
        check("rds2.state", {62'd0, a_state}, ST_STALLED);
        check("rds2.valid", {63'd0, a_valid}, 64'd0);
        a_stall = 1'b0;
        tick();
        check("rds3.pc", a_pc, 64'h3004);
        check_id("rds3", 32'hE000_3000, 64'h3004, 1'b1);

        // ---- back-to-back redirects: last target wins ----
        a_redirect = 1'b1; a_target = 64'h4000;
        tick();
        a_target = 64'h5008;
        tick();
        a_redirect = 1'b0;
        check("b2b.pc", a_pc, 64'h5008);
        check("b2b.rcnt", {32'd0, a_rcnt}, 64'd4);
        tick();
        check_id("b2b2", 32'hE000_5008, 64'h500C, 1'b1);

        // ---- reset together with redirect and stall ----
        a_reset = 1'b1; a_redirect = 1'b1; a_stall = 1'b1; a_target = 64'h6000;
        tick();
        a_redirect = 1'b0; a_stall = 1'b0;
        check("rstr.pc", a_pc, 64'h1000);
        check_id("rstr", NOP, 64'h0, 1'b0);
        check("rstr.rcnt", {32'd0, a_rcnt}, 64'd0);
        check("rstr.fcnt", {32'd0, a_fcnt}, 64'd0);
        check("rstr.state", {62'd0, a_state}, ST_RESET);

        // ---- PC wrap at top of address space ----
        a_startpc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        check("wrap.pc0", a_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        a_reset = 1'b0;
        tick();
        check("wrap.pc1", a_pc, 64'h0);
        check_id("wrap", 32'hEFFF_FFFC, 64'h0, 1'b1);

        // ---- 4-bit counter saturation on dut_b ----
        tick();
        b_reset = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 15) check("sat.fcnt15", {60'd0, b_fcnt}, 64'd15);
        end
        check("sat.fcnt20", {60'd0, b_fcnt}, 64'd15);
        check("sat.pc", b_pc, 64'd80);
        check("sat.rcnt", {60'd0, b_rcnt}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_unit
